mem_req_sched: RTL and testbench
================================

// Module: mem_req_sched
// PURPOSE
//  Round-robin request scheduler and response steerer between NUM_REQ L1-side requesters
//  (TC FSM, L1D-P, L1I-P, L1D-S, L1I-S) and the single data-router port.
//  Tags each granted request with its source ID and tracks per-requester outstanding count.
//  Routes tagged router responses back to their owning requester.
//  Sits inside mem_sys, directly behind the L1 request interfaces.
// PARAMETERS
//  NUM_REQ    5   number of requesters; index 0 = TC FSM
//  REQ_W      64  request payload width (addr+cmd+wdata, opaque here)
//  RSP_W      64  response payload width (opaque here)
//  MAX_OUTST  4   max outstanding requests per requester (>=1)
//  TAG_W      3   source tag width, $clog2(NUM_REQ) rounded up, >=1
// PORTS
//  clk         in   1              clock
//  rst         in   1              synchronous reset, active-high
//  req_valid   in   NUM_REQ        per-requester request valid
//  req_data    in   NUM_REQ*REQ_W  per-requester payload, requester i at [i*REQ_W +: REQ_W]
//  req_ready   out  NUM_REQ        request accepted when valid&ready
//  out_valid   out  1              request to router valid
//  out_data    out  REQ_W          granted payload
//  out_tag     out  TAG_W          source ID of out_data
//  out_ready   in   1              router accepts
//  rsp_valid   in   1              response from router
//  rsp_data    in   RSP_W          response payload
//  rsp_tag     in   TAG_W          destination requester ID
//  rsp_ready   out  1              response consumed
//  l1_rsp_valid out NUM_REQ        one-hot response valid to requesters
//  l1_rsp_data  out RSP_W          response payload, broadcast
//  l1_rsp_ready in  NUM_REQ        per-requester response ready
//  err_sticky  out  1              protocol error seen (bad tag or count underflow)
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_tag=0, req_ready=0, err_sticky=0.
//   Outstanding counters=0. RR pointer=0, so requester 0 has highest priority after reset.
//  Output stage: one register (out_valid/out_data/out_tag).
//   "load" = !out_valid | out_ready.
//  Eligibility: eligible[i] = req_valid[i] & (cnt[i] < MAX_OUTST).
//  Grant: when load, grant the first eligible requester starting at RR pointer, ascending, wrapping.
//   req_ready is one-hot of the grant, or 0 if nothing is granted.
//   req_ready is combinational from req_valid/cnt/out_ready; no comb path from req_data.
//  On grant i: out register <= {req_data[i], i}, out_valid<=1, RR pointer <= (i+1) mod NUM_REQ.
//   Latency is 1 cycle from the accepting edge to out_valid.
//   Back-to-back grants are possible every cycle while out_ready=1.
//  No grant while load: out_valid<=0 if out_ready, else hold. RR pointer is unchanged.
//  Out register contents hold stable while out_valid & !out_ready.
//  Response path is combinational, with no buffering:
//   l1_rsp_valid[k] = rsp_valid & (rsp_tag==k); rsp_ready = l1_rsp_ready[rsp_tag].
//  Bad tag (rsp_tag >= NUM_REQ): rsp_ready=1 (dropped), l1_rsp_valid=0, err_sticky<=1.
//  Counters: cnt[i] +1 on request handshake, -1 on response handshake to i.
//   Both in the same cycle: net unchanged.
//   Response to i when cnt[i]==0: cnt stays 0, err_sticky<=1, response still delivered.
//   cnt[i]==MAX_OUTST: i is masked out; it is not granted even if valid.
//  err_sticky clears only on rst.
//  rst mid-operation: a pending out_valid is dropped and counters are zeroed.
//   System-level reset of the router is required alongside.
// CONFIGURATION
//  MEM_SCHED_PRIO_EN defined:
//   Requester 0 (TC FSM), when eligible, wins over RR regardless of pointer.
//   The RR pointer is not updated on a priority grant.
//  Undefined: pure round-robin across all NUM_REQ requesters.
// STRUCTURE
//  Package mem_sys_pkg holds:
//   typedef logic [TAG_W-1:0] mem_src_tag_t
//   localparams SRC_TCFSM=0, SRC_L1DP=1, SRC_L1IP=2, SRC_L1DS=3, SRC_L1IS=4
//  One sub-module: mem_rr_pick.
//   Combinational N-way round-robin picker; inputs eligible vector and pointer.
//   Outputs one-hot grant and index.
//  Counters, output register and response steering stay in mem_req_sched.
// TESTING
//  1. After rst, req_valid=5'b11111, out_ready=1 -> grants 0,1,2,3,4,0 on consecutive cycles.
//     out_tag follows the grant one cycle later.
//  2. out_ready=0 with out_valid=1 for 3 cycles -> out_data/out_tag stable, req_ready=0.
//     Raising out_ready -> next grant in the same cycle.
//  3. Requester 2 issues MAX_OUTST=4 requests with no responses -> 5th request is not granted.
//     Response tag=2 -> requester 2 is granted again on the following load.
//  4. rsp_tag=3, l1_rsp_ready=5'b00000 -> l1_rsp_valid=5'b01000, rsp_ready=0.
//     Set ready[3] -> handshake, cnt[3] decrements.
//  5. rsp_tag=6 -> rsp_ready=1, no l1_rsp_valid, err_sticky=1 until rst.
//     Response to a requester with cnt 0 -> err_sticky=1.
//  6. With MEM_SCHED_PRIO_EN, requesters 0 and 3 both valid continuously -> 0 always wins.
//     Without it: 0,3 alternate.

Source files
------------

// File: rtl/mem_sys_pkg.sv
// Shared memory-system types: requester source tags and their fixed IDs.
package mem_sys_pkg;

  localparam int MEM_TAG_W = 3;

  typedef logic [MEM_TAG_W-1:0] mem_src_tag_t;

  localparam int SRC_TCFSM = 0;
  localparam int SRC_L1DP  = 1;
  localparam int SRC_L1IP  = 2;
  localparam int SRC_L1DS  = 3;
  localparam int SRC_L1IS  = 4;

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational N-way round-robin picker: first eligible index at or after ptr, wrapping.
module mem_rr_pick #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && eligible[j]) begin
        any = 1'b1;
        idx = j;
      end
      j = (j == IW'(N - 1)) ? '0 : j + IW'(1);
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/mem_req_sched.sv
// Round-robin request scheduler with source tagging and tagged response steering.
// Optional MEM_SCHED_PRIO_EN: requester 0 (TC FSM) preempts round-robin when eligible.
module mem_req_sched
  import mem_sys_pkg::*;
#(
  parameter int NUM_REQ   = 5,
  parameter int REQ_W     = 64,
  parameter int RSP_W     = 64,
  parameter int MAX_OUTST = 4,
  parameter int TAG_W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*REQ_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [REQ_W-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  input  logic                     out_ready,
  input  logic                     rsp_valid,
  input  logic [RSP_W-1:0]         rsp_data,
  input  logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_ready,
  output logic [NUM_REQ-1:0]       l1_rsp_valid,
  output logic [RSP_W-1:0]         l1_rsp_data,
  input  logic [NUM_REQ-1:0]       l1_rsp_ready,
  output logic                     err_sticky
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [CNT_W-1:0]   cnt [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] rr_grant;
  logic [TAG_W-1:0]   rr_idx;
  logic               rr_any;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [TAG_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               gnt_prio;
  logic [TAG_W-1:0]   rr_ptr;
  logic               load;
  logic               grant_fire;
  logic [REQ_W-1:0]   sel_data;
  logic [NUM_REQ-1:0] tag_match;
  logic [NUM_REQ-1:0] rsp_hs;
  logic [NUM_REQ-1:0] cnt_zero;
  logic               rsp_bad;
  logic               underflow;
  logic               vld_p0;
  logic [REQ_W-1:0]   out_data_p0;
  logic [TAG_W-1:0]   out_tag_p0;

  function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] cur,
                                               input logic inc, input logic dec);
    if (inc && !dec) return cur + CNT_W'(1);
    if (dec && !inc && cur != '0) return cur - CNT_W'(1);
    return cur;
  endfunction

  always_comb begin
    eligible = '0;
    cnt_zero = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTST));
      cnt_zero[i] = (cnt[i] == '0);
    end
  end

  mem_rr_pick #(.N(NUM_REQ), .IW(TAG_W)) u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (rr_grant),
    .idx      (rr_idx),
    .any      (rr_any)
  );

  always_comb begin
    gnt_vec  = rr_grant;
    gnt_idx  = rr_idx;
    gnt_any  = rr_any;
    gnt_prio = 1'b0;
`ifdef MEM_SCHED_PRIO_EN
    if (eligible[SRC_TCFSM]) begin
      gnt_vec  = NUM_REQ'(1) << SRC_TCFSM;
      gnt_idx  = TAG_W'(SRC_TCFSM);
      gnt_any  = 1'b1;
      gnt_prio = 1'b1;
    end
`endif
  end

  assign load       = !vld_p0 || out_ready;
  assign grant_fire = load && gnt_any && !rst;
  assign req_ready  = grant_fire ? gnt_vec : '0;

  // Payload mux keyed on the registered-path index only; req_data never reaches req_ready.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == TAG_W'(i)) sel_data = req_data[i*REQ_W +: REQ_W];
    end
  end

  // Stage p0: output register towards the data router
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      out_data_p0 <= '0;
      out_tag_p0  <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      if (gnt_any) begin
        vld_p0      <= 1'b1;
        out_data_p0 <= sel_data;
        out_tag_p0  <= gnt_idx;
        if (!gnt_prio)
          rr_ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
      end else begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = out_data_p0;
  assign out_tag   = out_tag_p0;

  always_comb begin
    tag_match    = '0;
    l1_rsp_valid = '0;
    rsp_ready    = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rsp_tag == TAG_W'(k)) begin
        tag_match[k]    = 1'b1;
        l1_rsp_valid[k] = rsp_valid;
        rsp_ready       = l1_rsp_ready[k];
      end
    end
  end

  assign l1_rsp_data = rsp_data;
  assign rsp_hs      = l1_rsp_valid & l1_rsp_ready;
  assign rsp_bad     = rsp_valid && (tag_match == '0);
  assign underflow   = |(rsp_hs & cnt_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      err_sticky <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= cnt_upd(cnt[i], req_ready[i], rsp_hs[i]);
      if (rsp_bad || underflow) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed and randomized bench for mem_req_sched against a cycle-level behavioural model.
module tb_mem_req_sched;
  import mem_sys_pkg::*;

  localparam int NUM_REQ   = 5;
  localparam int REQ_W     = 64;
  localparam int RSP_W     = 64;
  localparam int MAX_OUTST = 4;
  localparam int TAG_W     = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*REQ_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [REQ_W-1:0]         out_data;
  logic [TAG_W-1:0]         out_tag;
  logic                     out_ready;
  logic                     rsp_valid;
  logic [RSP_W-1:0]         rsp_data;
  mem_src_tag_t             rsp_tag;
  logic                     rsp_ready;
  logic [NUM_REQ-1:0]       l1_rsp_valid;
  logic [RSP_W-1:0]         l1_rsp_data;
  logic [NUM_REQ-1:0]       l1_rsp_ready;
  logic                     err_sticky;

  mem_req_sched #(
    .NUM_REQ(NUM_REQ), .REQ_W(REQ_W), .RSP_W(RSP_W), .MAX_OUTST(MAX_OUTST), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .l1_rsp_valid(l1_rsp_valid), .l1_rsp_data(l1_rsp_data), .l1_rsp_ready(l1_rsp_ready),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: output register, RR pointer, outstanding counts, sticky error.
  bit          m_vld = 1'b0;
  logic [63:0] m_data = '0;
  int          m_tag = 0;
  int          m_ptr = 0;
  int          m_cnt [NUM_REQ] = '{default: 0};
  bit          m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_REQ * 2; i++) req_data[i*32 +: 32] = $urandom;
  endtask

  // Compare every output with the model at the negedge, then advance the model over the posedge.
  task automatic cycle();
    int g, t, dt;
    bit ld, prio;
    logic [NUM_REQ-1:0] e_rr, e_l1;
    logic e_rrdy;
    @(negedge clk);
    ld   = !m_vld || out_ready;
    g    = -1;
    prio = 1'b0;
`ifdef MEM_SCHED_PRIO_EN
    if (req_valid[0] && m_cnt[0] < MAX_OUTST) begin
      g    = 0;
      prio = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (m_ptr + k) % NUM_REQ;
      if (g < 0 && req_valid[j] && m_cnt[j] < MAX_OUTST) g = j;
    end
    if (rst || !ld) g = -1;
    e_rr   = (g >= 0) ? NUM_REQ'(1 << g) : '0;
    t      = int'(rsp_tag);
    e_l1   = (rsp_valid && t < NUM_REQ) ? NUM_REQ'(1 << t) : '0;
    e_rrdy = (t < NUM_REQ) ? l1_rsp_ready[t] : 1'b1;
    chk("req_ready", 64'(req_ready), 64'(e_rr));
    chk("l1_rsp_valid", 64'(l1_rsp_valid), 64'(e_l1));
    chk("rsp_ready", 64'(rsp_ready), 64'(e_rrdy));
    chk("l1_rsp_data", l1_rsp_data, rsp_data);
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    chk("out_data", out_data, m_data);
    chk("out_tag", 64'(out_tag), 64'(m_tag));
    chk("err_sticky", 64'(err_sticky), 64'(m_err));
    if (rst) begin
      m_vld = 1'b0; m_data = '0; m_tag = 0; m_ptr = 0; m_err = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    end else begin
      if (ld) begin
        if (g >= 0) begin
          m_vld  = 1'b1;
          m_data = req_data[g*REQ_W +: REQ_W];
          m_tag  = g;
          if (!prio) m_ptr = (g + 1) % NUM_REQ;
        end else begin
          m_vld = 1'b0;
        end
      end
      dt = (rsp_valid && t < NUM_REQ && l1_rsp_ready[t]) ? t : -1;
      if (rsp_valid && t >= NUM_REQ) m_err = 1'b1;
      if (dt >= 0 && m_cnt[dt] == 0) m_err = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g == i && dt != i) m_cnt[i]++;
        else if (dt == i && g != i && m_cnt[i] > 0) m_cnt[i]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst_seq();
    rst = 1'b1; req_valid = '0; out_ready = 1'b0;
    rsp_valid = 1'b0; rsp_tag = '0; l1_rsp_ready = '0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] d0;
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; rsp_tag = '0; l1_rsp_ready = '0;
    repeat (2) cycle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    req_valid = '1; out_ready = 1'b1;
    #1 chk("rst_req_ready", 64'(req_ready), 64'd0);
    cycle();

    // Round-robin sweep from pointer 0
    rand_data();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t1_tag", 64'(out_tag), 64'(i % NUM_REQ));
      chk("t1_vld", 64'(out_valid), 64'd1);
    end

    // Stall holds the register even while inputs change
    d0 = req_data[63:0];
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle();
      chk("t2_data", out_data, d0);
      chk("t2_tag", 64'(out_tag), 64'd0);
      chk("t2_req_ready", 64'(req_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 chk("t2_regrant", 64'(req_ready), 64'b00010);
    cycle();
    chk("t2_tag_after", 64'(out_tag), 64'd1);

    // Outstanding limit on requester 2
    rst_seq();
    req_valid = 5'b00100; out_ready = 1'b1;
    repeat (MAX_OUTST) cycle();
    #1 chk("t3_masked", 64'(req_ready), 64'd0);
    cycle();
    rsp_valid = 1'b1; rsp_tag = 3'd2; l1_rsp_ready = 5'b00100;
    #1 chk("t3_masked_rsp", 64'(req_ready), 64'd0);
    chk("t3_rsp_ready", 64'(rsp_ready), 64'd1);
    cycle();
    rsp_valid = 1'b0;
    #1 chk("t3_unmasked", 64'(req_ready), 64'b00100);
    cycle();
    chk("t3_tag", 64'(out_tag), 64'd2);

    // Response steering and backpressure
    rst_seq();
    req_valid = 5'b01000; out_ready = 1'b1;
    cycle();
    req_valid = '0; rsp_data = {$urandom, $urandom};
    rsp_valid = 1'b1; rsp_tag = 3'd3; l1_rsp_ready = '0;
    #1 chk("t4_l1_valid", 64'(l1_rsp_valid), 64'b01000);
    chk("t4_rsp_ready0", 64'(rsp_ready), 64'd0);
    repeat (2) cycle();
    l1_rsp_ready = 5'b01000;
    #1 chk("t4_rsp_ready1", 64'(rsp_ready), 64'd1);
    cycle();
    chk("t4_no_err", 64'(err_sticky), 64'd0);
    cycle();
    chk("t5_underflow_err", 64'(err_sticky), 64'd1);
    rsp_valid = 1'b0;

    // Bad tag is dropped and flagged until reset
    rst_seq();
    chk("t5_err_clr", 64'(err_sticky), 64'd0);
    rsp_valid = 1'b1; rsp_tag = 3'd6; l1_rsp_ready = '1;
    #1 chk("t5_bad_ready", 64'(rsp_ready), 64'd1);
    chk("t5_bad_valid", 64'(l1_rsp_valid), 64'd0);
    cycle();
    rsp_valid = 1'b0;
    repeat (3) cycle();
    chk("t5_err_hold", 64'(err_sticky), 64'd1);
    rst_seq();
    cycle();
    chk("t5_err_rst", 64'(err_sticky), 64'd0);

    // Requesters 0 and 3 contending
    rst_seq();
    req_valid = 5'b01001; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int e;
`ifdef MEM_SCHED_PRIO_EN
      e = 0;
`else
      e = (i % 2 == 1) ? 3 : 0;
`endif
      cycle();
      chk("t6_tag", 64'(out_tag), 64'(e));
    end

    // Randomized traffic; responses only to requesters with work outstanding
    rst_seq();
    for (int n = 0; n < 600; n++) begin
      int t;
      rand_data();
      req_valid    = NUM_REQ'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      t            = $urandom_range(0, NUM_REQ - 1);
      rsp_tag      = TAG_W'(t);
      rsp_valid    = (m_cnt[t] > 0) && ($urandom_range(0, 1) == 1);
      rsp_data     = {$urandom, $urandom};
      l1_rsp_ready = NUM_REQ'($urandom);
      cycle();
    end
    chk("rand_no_err", 64'(err_sticky), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
